ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
Shares the single byte-wide DDR RAM interface port between two clients: the audio streamer (A) and the PicoBlaze/LCD control path (C). Performs round-robin arbitration, drives the RAM write and read-request/read-ack handshakes, and returns one-cycle completion strobes to each client. Sits between the clients and ram_interface_wrapper in the clkout domain.

Parameters:
ADDR_W, 26, RAM byte address width
DATA_W, 8, RAM data width
TIMEOUT_CYCLES, 1024, read-wait limit (used only with the optional feature)

Ports:
clk  in  1  system clock (RAM clkout domain)
reset  in  1  synchronous, active-low
a_req  in  1  audio request; held with a_we/a_addr/a_wdata stable until a_ack
a_we  in  1  1=write, 0=read
a_addr  in  ADDR_W  audio address
a_wdata  in  DATA_W  audio write data
a_ack  out  1  one-cycle completion strobe
a_rdata  out  DATA_W  read data, valid while a_ack=1
c_req, c_we, c_addr, c_wdata, c_ack, c_rdata  same as A, for the control client
ram_rdy  in  1  RAM ready
ram_rd_data_pres  in  1  read data present
ram_data_out  in  DATA_W  RAM read data
ram_address  out  ADDR_W  registered address
ram_data_in  out  DATA_W  registered write data
ram_write_enable  out  1  one-cycle write strobe
ram_read_request  out  1  one-cycle read strobe
ram_read_ack  out  1  one-cycle read acknowledge
busy  out  1  1 whenever state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; all outputs 0; last_grant=C. Any operation in flight is abandoned and no ack is issued.
- States: IDLE, WR, RD_REQ, RD_WAIT, RD_ACK, DONE.
- IDLE:
  - Requires ram_rdy=1 and at least one req.
  - Single requester is granted.
  - Both requesting: grant the client that is not last_grant. The first tie after reset therefore goes to A.
  - On grant: register addr/wdata/we into ram_address/ram_data_in, update last_grant, go to WR (we=1) or RD_REQ (we=0).
  - ram_rdy=0: stay in IDLE; requests remain pending.
- WR: ram_write_enable=1 for exactly this cycle -> DONE.
- DONE: ack of the granted client =1 for one cycle -> IDLE.
  - Write latency: request sampled at edge N, write strobe in cycle N+1, ack in cycle N+2.
- RD_REQ: ram_read_request=1 for one cycle -> RD_WAIT.
- RD_WAIT: wait for ram_rd_data_pres=1, then capture ram_data_out into the granted client's rdata register -> RD_ACK.
  - If ram_rd_data_pres is already 1 in the RD_WAIT entry cycle, capture immediately.
- RD_ACK: ram_read_ack=1 and the granted client's ack=1 in the same cycle; rdata valid -> IDLE.
- Request drop rules:
  - Requests are not sampled in DONE or RD_ACK, so a client dropping req on its ack cycle is never double-served.
  - A client that deasserts req before its ack is still completed; the result is discarded by the client.
- rdata registers hold their value until the next read completion for that client.
- At most one of ram_write_enable, ram_read_request, ram_read_ack is high in any cycle.
- Never a_ack and c_ack in the same cycle.
- ram_address and ram_data_in hold their values when idle.

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- Defined:
  - An 11-bit counter runs in RD_WAIT. When it reaches TIMEOUT_CYCLES-1 without ram_rd_data_pres, go to DONE.
  - The client receives its ack with rdata=8'hFF, and err is set (sticky until reset).
  - No ram_read_ack is issued on timeout.
- Undefined: RD_WAIT waits indefinitely, err is tied 0, and no counter logic exists.

Decomposition:
- Shared package ram_arb_pkg contains: state enum, client id constants (CLI_A=0, CLI_C=1), ADDR_W/DATA_W defaults, and the timeout rdata constant 8'hFF.
- One sub-module, ram_arb_rr: 2-way round-robin picker holding the last_grant register. Inputs: req vector and grant-enable. Outputs: one-hot grant.

Test Plan:
- Audio write only: a_req=1, a_we=1, a_addr=26'h10, a_wdata=8'h5A, ram_rdy=1 -> ram_write_enable one cycle later with ram_address=26'h10 and ram_data_in=8'h5A; a_ack exactly 2 cycles after the request is sampled.
- Control read: c_addr=26'h3, RAM model asserts rd_data_pres 5 cycles after read_request with data 8'hC3 -> c_rdata=8'hC3 and c_ack coincide with a single ram_read_ack pulse.
- Simultaneous requests held continuously for 4 transactions -> grants alternate A, C, A, C; never two acks in one cycle.
- ram_rdy=0 with a_req=1 for 20 cycles -> no RAM strobes, busy=0; grant occurs on the first cycle ram_rdy=1.
- reset=0 asserted during RD_WAIT -> all outputs 0 the next cycle, no ack; a new request is served normally afterwards.
- With RAM_ARB_TIMEOUT_EN defined, rd_data_pres is never asserted -> ack at 1024 cycles with rdata=8'hFF, err=1 and held until reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-client RAM access arbiter.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StRdAck,
    StDone
  } state_e;

  localparam logic CLI_A = 1'b0;
  localparam logic CLI_C = 1'b1;

  localparam int unsigned DefAddrW = 26;
  localparam int unsigned DefDataW = 8;

  // Read data returned to a client whose read timed out.
  localparam logic [7:0] TimeoutRdata = 8'hFF;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Client and RAM-side handshake bundle of the RAM access arbiter.
interface ram_access_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;

  logic              ram_rdy;
  logic              ram_rd_data_pres;
  logic [DATA_W-1:0] ram_data_out;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_write_enable;
  logic              ram_read_request;
  logic              ram_read_ack;

  // Arbiter view.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  ram_rdy, ram_rd_data_pres, ram_data_out,
    output ram_address, ram_data_in, ram_write_enable, ram_read_request, ram_read_ack
  );

  // Clients plus RAM wrapper view.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output ram_rdy, ram_rd_data_pres, ram_data_out,
    input  ram_address, ram_data_in, ram_write_enable, ram_read_request, ram_read_ack
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker; on a tie grants the client that was not granted last.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) begin
        grant = (last_q == CLI_A) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= CLI_C;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM port between audio (A) and control (C).
// Define RAM_ARB_TIMEOUT_EN to bound the read wait and flag timeouts on err.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_access_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 err
);

  state_e            state_q;
  logic              cli_q;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              grant_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec  = {bus.c_req, bus.a_req};
  assign grant_en = (state_q == StIdle) && bus.ram_rdy;

  ram_arb_rr u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req_vec),
    .grant_en (grant_en),
    .grant    (grant)
  );

  assign sel_we    = grant[1] ? bus.c_we    : bus.a_we;
  assign sel_addr  = grant[1] ? bus.c_addr  : bus.a_addr;
  assign sel_wdata = grant[1] ? bus.c_wdata : bus.a_wdata;

  assign busy = (state_q != StIdle);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam logic [10:0] TimeoutLast = 11'(TIMEOUT_CYCLES - 1);
  logic [10:0] tmo_cnt_q;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q              <= StIdle;
      cli_q                <= CLI_A;
      bus.ram_address      <= '0;
      bus.ram_data_in      <= '0;
      bus.ram_write_enable <= 1'b0;
      bus.ram_read_request <= 1'b0;
      bus.ram_read_ack     <= 1'b0;
      bus.a_ack            <= 1'b0;
      bus.c_ack            <= 1'b0;
      bus.a_rdata          <= '0;
      bus.c_rdata          <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      tmo_cnt_q            <= '0;
      err_q                <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.ram_write_enable <= 1'b0;
      bus.ram_read_request <= 1'b0;
      bus.ram_read_ack     <= 1'b0;
      bus.a_ack            <= 1'b0;
      bus.c_ack            <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            cli_q           <= grant[1];
            bus.ram_address <= sel_addr;
            bus.ram_data_in <= sel_wdata;
            if (sel_we) begin
              bus.ram_write_enable <= 1'b1;
              state_q              <= StWr;
            end else begin
              bus.ram_read_request <= 1'b1;
              state_q              <= StRdReq;
            end
          end
        end

        StWr: begin
          bus.a_ack <= (cli_q == CLI_A);
          bus.c_ack <= (cli_q == CLI_C);
          state_q   <= StDone;
        end

        StRdReq: begin
`ifdef RAM_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q <= StRdWait;
        end

        StRdWait: begin
          if (bus.ram_rd_data_pres) begin
            if (cli_q == CLI_C) begin
              bus.c_rdata <= bus.ram_data_out;
            end else begin
              bus.a_rdata <= bus.ram_data_out;
            end
            bus.ram_read_ack <= 1'b1;
            bus.a_ack        <= (cli_q == CLI_A);
            bus.c_ack        <= (cli_q == CLI_C);
            state_q          <= StRdAck;
          end
`ifdef RAM_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TimeoutLast) begin
            // Give up: complete the client with the poison byte, no RAM read ack.
            if (cli_q == CLI_C) begin
              bus.c_rdata <= DATA_W'(TimeoutRdata);
            end else begin
              bus.a_rdata <= DATA_W'(TimeoutRdata);
            end
            err_q     <= 1'b1;
            bus.a_ack <= (cli_q == CLI_A);
            bus.c_ack <= (cli_q == CLI_C);
            state_q   <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 11'd1;
          end
`endif
        end

        StRdAck: state_q <= StIdle;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter with a behavioural RAM and client model.
module tb_ram_access_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 1024;

  typedef struct {
    int          cyc;
    logic [25:0] addr;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    int         cyc;
    bit         is_c;
    logic [7:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, err;

  ram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_access_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ev_t  we_log[$];
  ev_t  rr_log[$];
  int   rack_log[$];
  ack_t ack_log[$];
  int   dbl_cnt = 0;
  int   multi_cnt = 0;
  int   busy_cycles = 0;

  logic [7:0] mem [logic [25:0]];
  logic [7:0] ref_mem [logic [25:0]];
  int rd_delay = 3;
  bit rd_rand = 1'b0;
  int rd_cnt = 0;
  bit rand_done = 1'b0;
  int done_a = 0;
  int done_c = 0;

  function automatic logic [7:0] init_val(input logic [25:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observation log plus RAM wrapper model (read data after a delay, as a one-cycle pulse).
  initial forever begin
    @(negedge clk);
    if (bus.ram_write_enable === 1'b1) we_log.push_back(ev_t'{cyc, bus.ram_address, bus.ram_data_in});
    if (bus.ram_read_request === 1'b1) rr_log.push_back(ev_t'{cyc, bus.ram_address, 8'h00});
    if (bus.ram_read_ack === 1'b1) rack_log.push_back(cyc);
    if (bus.a_ack === 1'b1) ack_log.push_back(ack_t'{cyc, 1'b0, bus.a_rdata});
    if (bus.c_ack === 1'b1) ack_log.push_back(ack_t'{cyc, 1'b1, bus.c_rdata});
    if (bus.a_ack === 1'b1 && bus.c_ack === 1'b1) dbl_cnt++;
    if (int'(bus.ram_write_enable === 1'b1) + int'(bus.ram_read_request === 1'b1)
        + int'(bus.ram_read_ack === 1'b1) > 1) multi_cnt++;
    if (busy === 1'b1) busy_cycles++;

    if (reset !== 1'b1) begin
      rd_cnt = 0;
      bus.ram_rd_data_pres = 1'b0;
    end else begin
      if (bus.ram_write_enable === 1'b1) mem[bus.ram_address] = bus.ram_data_in;
      bus.ram_rd_data_pres = 1'b0;
      bus.ram_data_out = 8'($urandom);
      if (bus.ram_read_request === 1'b1) begin
        rd_cnt = rd_rand ? int'($urandom_range(1, 6)) : rd_delay;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.ram_rd_data_pres = 1'b1;
          bus.ram_data_out = mem.exists(bus.ram_address) ? mem[bus.ram_address]
                                                         : init_val(bus.ram_address);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_log.delete();
    rr_log.delete();
    rack_log.delete();
    ack_log.delete();
    dbl_cnt = 0;
    multi_cnt = 0;
    busy_cycles = 0;
  endtask

  task automatic drive(input bit is_c, input bit we, input logic [25:0] addr,
                       input logic [7:0] wd);
    if (is_c) begin
      bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd; bus.c_req = 1'b1;
    end else begin
      bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_req = 1'b1;
    end
  endtask

  task automatic drop_req(input bit is_c);
    if (is_c) bus.c_req = 1'b0;
    else bus.a_req = 1'b0;
  endtask

  task automatic wait_ack(input bit is_c, input int bound, output bit got, output int acyc,
                          output logic [7:0] rd);
    got = 1'b0;
    acyc = 0;
    rd = 8'h00;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((is_c ? bus.c_ack : bus.a_ack) === 1'b1) begin
        got = 1'b1;
        acyc = cyc;
        rd = is_c ? bus.c_rdata : bus.a_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++;
    if ({bus.ram_write_enable, bus.ram_read_request, bus.ram_read_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000",
               {bus.ram_write_enable, bus.ram_read_request, bus.ram_read_ack});
    end
    checks++;
    if ({bus.a_ack, bus.c_ack, bus.a_rdata, bus.c_rdata} !== 18'h0) begin
      errors++;
      $display("FAIL reset_client got %h want 0", {bus.a_ack, bus.c_ack, bus.a_rdata, bus.c_rdata});
    end
    checks++;
    if ({bus.ram_address, bus.ram_data_in} !== 34'h0) begin
      errors++;
      $display("FAIL reset_ram_bus got %h want 0", {bus.ram_address, bus.ram_data_in});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_audio_write();
    bit got; int acyc; int p; logic [7:0] rd;
    clear_logs();
    drive(1'b0, 1'b1, 26'h10, 8'h5A);
    p = cyc;
    wait_ack(1'b0, 20, got, acyc, rd);
    step();
    drop_req(1'b0);
    repeat (3) step();
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", got); end
    checks++;
    if (acyc !== p + 2) begin errors++; $display("FAIL wr_ack_cycle got %0d want %0d", acyc, p + 2); end
    checks++;
    if (we_log.size() !== 1) begin errors++; $display("FAIL wr_strobes got %0d want 1", we_log.size()); end
    else begin
      checks++;
      if (we_log[0].cyc !== p + 1) begin
        errors++; $display("FAIL wr_strobe_cycle got %0d want %0d", we_log[0].cyc, p + 1);
      end
      checks++;
      if ({we_log[0].addr, we_log[0].data} !== {26'h10, 8'h5A}) begin
        errors++;
        $display("FAIL wr_addr_data got %h/%h want 10/5a", we_log[0].addr, we_log[0].data);
      end
    end
    checks++;
    if (rr_log.size() !== 0) begin errors++; $display("FAIL wr_no_read got %0d want 0", rr_log.size()); end
  endtask

  task automatic test_control_read();
    bit got; int acyc; int p; logic [7:0] rd;
    clear_logs();
    mem[26'h3] = 8'hC3;
    rd_delay = 5;
    drive(1'b1, 1'b0, 26'h3, 8'h00);
    p = cyc;
    wait_ack(1'b1, 40, got, acyc, rd);
    step();
    drop_req(1'b1);
    repeat (3) step();
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", got); end
    checks++;
    if (rd !== 8'hC3) begin errors++; $display("FAIL rd_data got %h want c3", rd); end
    checks++;
    if (rr_log.size() !== 1) begin errors++; $display("FAIL rd_req_count got %0d want 1", rr_log.size()); end
    else begin
      checks++;
      if ({rr_log[0].cyc, rr_log[0].addr} !== {p + 1, 26'h3}) begin
        errors++; $display("FAIL rd_req got cyc %0d addr %h want %0d/3", rr_log[0].cyc, rr_log[0].addr, p + 1);
      end
      checks++;
      if (acyc !== rr_log[0].cyc + 6) begin
        errors++; $display("FAIL rd_latency got %0d want %0d", acyc, rr_log[0].cyc + 6);
      end
    end
    checks++;
    if (rack_log.size() !== 1) begin errors++; $display("FAIL rd_rack_count got %0d want 1", rack_log.size()); end
    else begin
      checks++;
      if (rack_log[0] !== acyc) begin errors++; $display("FAIL rd_rack_cycle got %0d want %0d", rack_log[0], acyc); end
    end
    checks++;
    if (ack_log.size() !== 1) begin errors++; $display("FAIL rd_acks got %0d want 1", ack_log.size()); end
  endtask

  task automatic test_rr_alternate();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    clear_logs();
    drive(1'b0, 1'b1, 26'h20, 8'hA1);
    drive(1'b1, 1'b1, 26'h21, 8'hC1);
    for (int i = 0; i < 60; i++) begin
      step();
      if (ack_log.size() >= 4) break;
    end
    drop_req(1'b0);
    drop_req(1'b1);
    repeat (5) step();
    checks++;
    if (ack_log.size() !== 4) begin errors++; $display("FAIL rr_acks got %0d want 4", ack_log.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_log[k].is_c !== bit'(k % 2)) begin
          errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, ack_log[k].is_c, k % 2);
        end
      end
    end
    checks++;
    if (dbl_cnt !== 0) begin errors++; $display("FAIL rr_double_ack got %0d want 0", dbl_cnt); end
    checks++;
    if (we_log.size() !== 4) begin errors++; $display("FAIL rr_writes got %0d want 4", we_log.size()); end
  endtask

  task automatic test_rdy_low();
    bit got; int acyc; int q; logic [7:0] rd;
    bus.ram_rdy = 1'b0;
    clear_logs();
    drive(1'b0, 1'b1, 26'h30, 8'h33);
    repeat (20) step();
    checks++;
    if (we_log.size() + rr_log.size() + rack_log.size() !== 0) begin
      errors++; $display("FAIL rdy_strobes got %0d want 0", we_log.size() + rr_log.size());
    end
    checks++;
    if (busy_cycles !== 0) begin errors++; $display("FAIL rdy_busy got %0d want 0", busy_cycles); end
    bus.ram_rdy = 1'b1;
    q = cyc;
    wait_ack(1'b0, 20, got, acyc, rd);
    step();
    drop_req(1'b0);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL rdy_ack got %b want 1", got); end
    checks++;
    if (we_log.size() !== 1) begin errors++; $display("FAIL rdy_write got %0d want 1", we_log.size()); end
    else begin
      checks++;
      if (we_log[0].cyc !== q + 1) begin
        errors++; $display("FAIL rdy_grant_cycle got %0d want %0d", we_log[0].cyc, q + 1);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit got; int acyc; logic [7:0] rd;
    clear_logs();
    rd_delay = 0;
    drive(1'b1, 1'b0, 26'h7, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step();
      if (rr_log.size() > 0) break;
    end
    repeat (2) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++;
    if ({bus.ram_write_enable, bus.ram_read_request, bus.ram_read_ack, bus.a_ack, bus.c_ack} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_strobes got %b want 0",
        {bus.ram_write_enable, bus.ram_read_request, bus.ram_read_ack, bus.a_ack, bus.c_ack});
    end
    checks++;
    if ({bus.ram_address, bus.c_rdata, bus.a_rdata} !== 42'h0) begin
      errors++; $display("FAIL rst_mid_regs got %h want 0", {bus.ram_address, bus.c_rdata, bus.a_rdata});
    end
    drop_req(1'b1);
    reset = 1'b1;
    repeat (10) step();
    checks++;
    if (ack_log.size() + rack_log.size() !== 0) begin
      errors++; $display("FAIL rst_mid_no_ack got %0d want 0", ack_log.size() + rack_log.size());
    end
    rd_delay = 2;
    mem[26'h44] = 8'h96;
    drive(1'b0, 1'b0, 26'h44, 8'h00);
    wait_ack(1'b0, 30, got, acyc, rd);
    step();
    drop_req(1'b0);
    checks++;
    if ({got, rd} !== {1'b1, 8'h96}) begin
      errors++; $display("FAIL rst_mid_after got ack %b data %h want 1/96", got, rd);
    end
  endtask

  task automatic client_run(input bit is_c, input int n);
    bit got; int acyc; logic [7:0] rd; logic [7:0] exp;
    bit we; logic [25:0] addr; logic [7:0] wd;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) step();
      we = 1'($urandom_range(0, 1));
      addr = 26'h100 + 26'($urandom_range(0, 7));
      wd = 8'($urandom);
      drive(is_c, we, addr, wd);
      wait_ack(is_c, 200, got, acyc, rd);
      checks++;
      if (got !== 1'b1) begin
        errors++; $display("FAIL rand_ack client %0d txn %0d got none want ack", is_c, t);
      end else begin
        if (is_c) done_c++;
        else done_a++;
        if (we) begin
          ref_mem[addr] = wd;
        end else begin
          exp = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
          checks++;
          if (rd !== exp) begin
            errors++; $display("FAIL rand_rdata client %0d addr %h got %h want %h", is_c, addr, rd, exp);
          end
        end
      end
      step();
      drop_req(is_c);
    end
  endtask

  task automatic test_random();
    mem.delete();
    ref_mem.delete();
    rd_rand = 1'b1;
    rand_done = 1'b0;
    done_a = 0;
    done_c = 0;
    clear_logs();
    fork
      begin
        fork
          client_run(1'b0, 12);
          client_run(1'b1, 12);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          bus.ram_rdy = ($urandom_range(0, 4) != 0);
        end
        bus.ram_rdy = 1'b1;
      end
    join
    rd_rand = 1'b0;
    repeat (4) step();
    checks++;
    if (dbl_cnt !== 0) begin errors++; $display("FAIL rand_double_ack got %0d want 0", dbl_cnt); end
    checks++;
    if (multi_cnt !== 0) begin errors++; $display("FAIL rand_multi_strobe got %0d want 0", multi_cnt); end
    checks++;
    if (ack_log.size() !== done_a + done_c) begin
      errors++; $display("FAIL rand_ack_total got %0d want %0d", ack_log.size(), done_a + done_c);
    end
  endtask

`ifdef RAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit got; int acyc; logic [7:0] rd;
    clear_logs();
    rd_delay = 0;
    drive(1'b0, 1'b0, 26'h55, 8'h00);
    wait_ack(1'b0, TO + 100, got, acyc, rd);
    step();
    drop_req(1'b0);
    checks++;
    if ({got, rd} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL tmo_ack got ack %b data %h want 1/ff", got, rd);
    end
    checks++;
    if (rack_log.size() !== 0) begin errors++; $display("FAIL tmo_rack got %0d want 0", rack_log.size()); end
    if (rr_log.size() == 1) begin
      checks++;
      if (acyc !== rr_log[0].cyc + int'(TO) + 1) begin
        errors++; $display("FAIL tmo_latency got %0d want %0d", acyc, rr_log[0].cyc + int'(TO) + 1);
      end
    end
    repeat (20) step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b want 1", err); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_reset got %b want 0", err); end
  endtask
`endif

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.ram_rdy = 1'b1;
    bus.ram_rd_data_pres = 1'b0;
    bus.ram_data_out = '0;
    test_reset();
    test_audio_write();
    test_control_read();
    test_rr_alternate();
    test_rdy_low();
    test_reset_mid_read();
    test_random();
`ifdef RAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
